// File: rtl/asa_noc_enc_ser_if.sv
// ---------------------------------------------------------------------------
// asa_noc_enc_ser_if
//   Bundles the accelerator response port, the NoC header port and the
//   AXI-Stream egress of the serializer into one interface.
//
//   master : serializer view (consumes header/response, drives the stream)
//   slave  : environment view (produces header/response, sinks the stream)
//
//   header_in/header_vld/header_rdy   NoC header word handshake
//   resp_val/resp_rdy/resp_fields     response message handshake,
//                                     field i at [i*FIELD_W +: FIELD_W]
//   stream_out_T*                     AXI-Stream egress beat
// ---------------------------------------------------------------------------
interface asa_noc_enc_ser_if #(
    parameter int DATA_W     = 32,
    parameter int FIELD_W    = 64,
    parameter int NUM_FIELDS = 3
);
    logic [DATA_W-1:0]             header_in;
    logic                          header_vld;
    logic                          header_rdy;
    logic                          resp_val;
    logic                          resp_rdy;
    logic [NUM_FIELDS*FIELD_W-1:0] resp_fields;
    logic                          stream_out_TREADY;
    logic                          stream_out_TVALID;
    logic [DATA_W-1:0]             stream_out_TDATA;
    logic [DATA_W/8-1:0]           stream_out_TKEEP;
    logic                          stream_out_TLAST;

    modport master (
        input  header_in, header_vld, resp_val, resp_fields, stream_out_TREADY,
        output header_rdy, resp_rdy,
        output stream_out_TVALID, stream_out_TDATA, stream_out_TKEEP, stream_out_TLAST
    );

    modport slave (
        output header_in, header_vld, resp_val, resp_fields, stream_out_TREADY,
        input  header_rdy, resp_rdy,
        input  stream_out_TVALID, stream_out_TDATA, stream_out_TKEEP, stream_out_TLAST
    );
endinterface

// File: rtl/asa_noc_enc_ser.sv
// ---------------------------------------------------------------------------
// asa_noc_enc_ser
//   Serializes one ASA accelerator response message (NUM_FIELDS fields of
//   FIELD_W bits) plus an optional NoC header word onto an AXI-Stream egress.
//   Beat order: header (if HDR_EN), payload words field-major with the most
//   significant word of each field first, then zero padding up to the next
//   power of two (if PAD_POW2). TLAST marks the final beat.
//
//   clk_ctrl          sole clock
//   clk_ctrl_rst_low  asynchronous active-low reset
//   bus (master)      header / response inputs and stream egress
// ---------------------------------------------------------------------------
module asa_noc_enc_ser #(
    parameter int DATA_W     = 32,
    parameter int FIELD_W    = 64,
    parameter int NUM_FIELDS = 3,
    parameter int HDR_EN     = 1,
    parameter int PAD_POW2   = 1
) (
    input  logic              clk_ctrl,
    input  logic              clk_ctrl_rst_low,
    asa_noc_enc_ser_if.master bus
);

    localparam int WPF     = FIELD_W / DATA_W;
    localparam int PAY_W   = NUM_FIELDS * WPF;
    localparam int TOT_PAY = (PAD_POW2 != 0) ? (1 << $clog2(PAY_W)) : PAY_W;
    localparam int IDX_W   = $clog2(TOT_PAY + 1);
    localparam int DEPTH   = 1 << IDX_W;
    localparam bit HAS_PAD = (TOT_PAY > PAY_W);
    localparam bit USE_HDR = (HDR_EN != 0);

    localparam logic [IDX_W-1:0] LAST_PAY = IDX_W'(PAY_W - 1);
    localparam logic [IDX_W-1:0] LAST_TOT = IDX_W'(TOT_PAY - 1);

    generate
        if ((FIELD_W % DATA_W) != 0) begin : g_bad_field_w
            $error("asa_noc_enc_ser: FIELD_W must be a multiple of DATA_W");
        end
        if (NUM_FIELDS < 1) begin : g_bad_num_fields
            $error("asa_noc_enc_ser: NUM_FIELDS must be at least 1");
        end
        if ((DATA_W % 8) != 0) begin : g_bad_data_w
            $error("asa_noc_enc_ser: DATA_W must be a multiple of 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAY,
        PAD
    } state_t;

    state_t                        state;
    state_t                        state_nxt;
    logic [IDX_W-1:0]              idx;
    logic [IDX_W-1:0]              idx_nxt;
    logic                          run;
    logic                          accept;
    logic [DATA_W-1:0]             hdr_q;
    logic [NUM_FIELDS*FIELD_W-1:0] fields_q;
    logic [DATA_W-1:0]             words [DEPTH];

    // Word table indexed directly by idx. Its depth is a full power of two of
    // the idx width so every idx value selects a defined entry; entries past
    // the payload are zero, which is exactly what the pad beats must carry.
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_words
            if (i < PAY_W) begin : g_pay
                assign words[i] =
                    fields_q[(i / WPF) * FIELD_W + FIELD_W - 1 - (i % WPF) * DATA_W -: DATA_W];
            end else begin : g_zero
                assign words[i] = '0;
            end
        end
    endgenerate

    // run stays low for the first clock after reset release so nothing is
    // accepted while the reset deassertion is still settling.
    assign accept = (state == IDLE) && run && bus.resp_val && (bus.header_vld || !USE_HDR);

    // State register; the message and header are captured on accept and then
    // held untouched for the whole packet.
    always_ff @(posedge clk_ctrl or negedge clk_ctrl_rst_low) begin
        if (!clk_ctrl_rst_low) begin
            state    <= IDLE;
            idx      <= '0;
            run      <= 1'b0;
            hdr_q    <= '0;
            fields_q <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            run   <= 1'b1;
            if (accept) begin
                hdr_q    <= bus.header_in;
                fields_q <= bus.resp_fields;
            end
        end
    end

    // Next-state logic. Every beat advances only on a TREADY handshake, so a
    // stalled beat keeps state and idx, which keeps TDATA/TLAST stable.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = USE_HDR ? HDR : PAY;
                    idx_nxt   = '0;
                end
            end
            HDR: begin
                if (bus.stream_out_TREADY) begin
                    state_nxt = PAY;
                    idx_nxt   = '0;
                end
            end
            PAY: begin
                if (bus.stream_out_TREADY) begin
                    if (idx == LAST_PAY) begin
                        if (HAS_PAD) begin
                            state_nxt = PAD;
                            idx_nxt   = idx + 1'b1;
                        end else begin
                            state_nxt = IDLE;
                            idx_nxt   = '0;
                        end
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            PAD: begin
                if (bus.stream_out_TREADY) begin
                    if (idx == LAST_TOT) begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // Outputs decode only registered state, so there is no combinational path
    // from TREADY to TVALID/TDATA/TLAST.
    always_comb begin
        bus.stream_out_TVALID = 1'b0;
        bus.stream_out_TDATA  = '0;
        bus.stream_out_TLAST  = 1'b0;
        bus.resp_rdy          = 1'b0;
        bus.header_rdy        = 1'b0;
        case (state)
            IDLE: begin
                bus.resp_rdy   = run;
                bus.header_rdy = run && USE_HDR;
            end
            HDR: begin
                bus.stream_out_TVALID = 1'b1;
                bus.stream_out_TDATA  = hdr_q;
            end
            PAY: begin
                bus.stream_out_TVALID = 1'b1;
                bus.stream_out_TDATA  = words[idx];
                bus.stream_out_TLAST  = !HAS_PAD && (idx == LAST_PAY);
            end
            PAD: begin
                bus.stream_out_TVALID = 1'b1;
                bus.stream_out_TDATA  = words[idx];
                bus.stream_out_TLAST  = (idx == LAST_TOT);
            end
            default: begin
                bus.stream_out_TVALID = 1'b0;
            end
        endcase
        bus.stream_out_TKEEP = {(DATA_W/8){bus.stream_out_TVALID}};
    end

endmodule

// File: tb/tb_asa_noc_enc_ser.sv
// ---------------------------------------------------------------------------
// tb_asa_noc_enc_ser
//   Bench for asa_noc_enc_ser with three configurations:
//   u0 defaults, u1 without header and padding, u2 with five 32-bit fields.
//   Expected beats are queued when a message is driven and popped on each
//   stream handshake.
// ---------------------------------------------------------------------------
module tb_asa_noc_enc_ser;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic  clk   = 1'b0;
    logic  rst_n = 1'b0;
    int    vectors     = 0;
    int    miscompares = 0;
    beat_t exp_q[$];

    asa_noc_enc_ser_if #(.DATA_W(32), .FIELD_W(64), .NUM_FIELDS(3)) if0 ();
    asa_noc_enc_ser_if #(.DATA_W(32), .FIELD_W(64), .NUM_FIELDS(3)) if1 ();
    asa_noc_enc_ser_if #(.DATA_W(32), .FIELD_W(32), .NUM_FIELDS(5)) if2 ();

    asa_noc_enc_ser #(.DATA_W(32), .FIELD_W(64), .NUM_FIELDS(3), .HDR_EN(1), .PAD_POW2(1)) u0 (
        .clk_ctrl(clk), .clk_ctrl_rst_low(rst_n), .bus(if0.master));
    asa_noc_enc_ser #(.DATA_W(32), .FIELD_W(64), .NUM_FIELDS(3), .HDR_EN(0), .PAD_POW2(0)) u1 (
        .clk_ctrl(clk), .clk_ctrl_rst_low(rst_n), .bus(if1.master));
    asa_noc_enc_ser #(.DATA_W(32), .FIELD_W(32), .NUM_FIELDS(5), .HDR_EN(1), .PAD_POW2(1)) u2 (
        .clk_ctrl(clk), .clk_ctrl_rst_low(rst_n), .bus(if2.master));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idle_inputs();
        if0.header_in = '0; if0.header_vld = 1'b0; if0.resp_val = 1'b0; if0.resp_fields = '0;
        if0.stream_out_TREADY = 1'b0;
        if1.header_in = '0; if1.header_vld = 1'b0; if1.resp_val = 1'b0; if1.resp_fields = '0;
        if1.stream_out_TREADY = 1'b0;
        if2.header_in = '0; if2.header_vld = 1'b0; if2.resp_val = 1'b0; if2.resp_fields = '0;
        if2.stream_out_TREADY = 1'b0;
    endtask

    // Reference model for a 3 x 64-bit message: high word of each field first.
    task automatic push3(input logic [31:0] hdr, input logic [63:0] a, input logic [63:0] k,
                         input logic [63:0] d, input bit with_hdr, input int npad);
        logic [31:0] w [6];
        w = '{a[63:32], a[31:0], k[63:32], k[31:0], d[63:32], d[31:0]};
        if (with_hdr) exp_q.push_back('{data: hdr, last: 1'b0});
        for (int i = 0; i < 6; i++) exp_q.push_back('{data: w[i], last: (npad == 0 && i == 5)});
        for (int p = 0; p < npad; p++) exp_q.push_back('{data: 32'h0, last: (p == npad - 1)});
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        vectors++;
        if ({if0.stream_out_TVALID, if0.stream_out_TLAST, if0.resp_rdy, if0.header_rdy} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL rst_ctrl: got %b want 0000",
                     {if0.stream_out_TVALID, if0.stream_out_TLAST, if0.resp_rdy, if0.header_rdy});
        end
        vectors++;
        if ({if0.stream_out_TDATA, if0.stream_out_TKEEP} !== 36'h0) begin
            miscompares++;
            $display("[TB] FAIL rst_data: got %h/%h want 0/0", if0.stream_out_TDATA, if0.stream_out_TKEEP);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({if0.resp_rdy, if0.header_rdy, if0.stream_out_TVALID} !== 3'b110) begin
            miscompares++;
            $display("[TB] FAIL idle_rdy0: got %b want 110", {if0.resp_rdy, if0.header_rdy, if0.stream_out_TVALID});
        end
        vectors++;
        if ({if1.resp_rdy, if1.header_rdy} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL idle_rdy1: got %b want 10", {if1.resp_rdy, if1.header_rdy});
        end
    endtask

    // T1 with TREADY held high, T2 with TREADY toggling every cycle.
    task automatic test_default();
        beat_t       e;
        int          cyc;
        bit          held;
        logic [31:0] hd;
        logic        hl;
        for (int pass = 0; pass < 2; pass++) begin
            @(posedge clk); #1;
            if0.header_in   = 32'hA5A50001;
            if0.resp_fields = {64'h9999AAAA_BBBBCCCC, 64'h55556666_77778888, 64'h11112222_33334444};
            if0.header_vld  = 1'b1;
            if0.resp_val    = 1'b1;
            if0.stream_out_TREADY = 1'b1;
            push3(32'hA5A50001, 64'h11112222_33334444, 64'h55556666_77778888, 64'h9999AAAA_BBBBCCCC, 1'b1, 2);
            @(negedge clk);
            vectors++;
            if (if0.resp_rdy !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL dflt_accept: got %b want 1", if0.resp_rdy);
            end
            @(posedge clk); #1;
            if0.header_vld = 1'b0; if0.resp_val = 1'b0; if0.resp_fields = '0; if0.header_in = '0;
            if0.stream_out_TREADY = (pass == 0);
            cyc  = 0;
            held = 1'b0;
            while (exp_q.size() > 0 && cyc < 60) begin
                @(negedge clk);
                if (held) begin
                    vectors++;
                    if (if0.stream_out_TVALID !== 1'b1 || if0.stream_out_TDATA !== hd || if0.stream_out_TLAST !== hl) begin
                        miscompares++;
                        $display("[TB] FAIL dflt_hold: got %b/%h/%b want 1/%h/%b",
                                 if0.stream_out_TVALID, if0.stream_out_TDATA, if0.stream_out_TLAST, hd, hl);
                    end
                end
                vectors++;
                if (if0.resp_rdy !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL dflt_busy_rdy: got %b want 0", if0.resp_rdy);
                end
                if (if0.stream_out_TVALID === 1'b1 && if0.stream_out_TREADY === 1'b1) begin
                    e = exp_q.pop_front();
                    vectors++;
                    if ({if0.stream_out_TDATA, if0.stream_out_TLAST, if0.stream_out_TKEEP} !== {e.data, e.last, 4'hF}) begin
                        miscompares++;
                        $display("[TB] FAIL dflt_beat: got %h/%b/%h want %h/%b/f",
                                 if0.stream_out_TDATA, if0.stream_out_TLAST, if0.stream_out_TKEEP, e.data, e.last);
                    end
                end
                held = (if0.stream_out_TVALID === 1'b1) && (if0.stream_out_TREADY !== 1'b1);
                hd   = if0.stream_out_TDATA;
                hl   = if0.stream_out_TLAST;
                @(posedge clk); #1;
                if0.stream_out_TREADY = (pass == 0) ? 1'b1 : ~if0.stream_out_TREADY;
                cyc++;
            end
            vectors++;
            if (exp_q.size() != 0) begin
                miscompares++;
                $display("[TB] FAIL dflt_count: got %0d beats missing want 0", exp_q.size());
                exp_q.delete();
            end
            @(negedge clk);
            vectors++;
            if ({if0.stream_out_TVALID, if0.resp_rdy} !== 2'b01) begin
                miscompares++;
                $display("[TB] FAIL dflt_bubble: got %b want 01", {if0.stream_out_TVALID, if0.resp_rdy});
            end
        end
    endtask

    // T3: response waits for its header; nothing may be accepted meanwhile.
    task automatic test_hdr_wait();
        beat_t       e;
        int          cyc;
        logic [31:0] h;
        logic [63:0] a, k, d;
        h = $urandom; a = {$urandom, $urandom}; k = {$urandom, $urandom}; d = {$urandom, $urandom};
        @(posedge clk); #1;
        if0.header_in = h; if0.resp_fields = {d, k, a};
        if0.resp_val = 1'b1; if0.header_vld = 1'b0; if0.stream_out_TREADY = 1'b1;
        push3(h, a, k, d, 1'b1, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({if0.stream_out_TVALID, if0.resp_rdy, if0.header_rdy} !== 3'b011) begin
                miscompares++;
                $display("[TB] FAIL wait_hdr: got %b want 011",
                         {if0.stream_out_TVALID, if0.resp_rdy, if0.header_rdy});
            end
            @(posedge clk); #1;
        end
        if0.header_vld = 1'b1;
        @(posedge clk); #1;
        if0.header_vld = 1'b0; if0.resp_val = 1'b0;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 40) begin
            @(negedge clk);
            if (if0.stream_out_TVALID === 1'b1) begin
                e = exp_q.pop_front();
                vectors++;
                if ({if0.stream_out_TDATA, if0.stream_out_TLAST} !== {e.data, e.last}) begin
                    miscompares++;
                    $display("[TB] FAIL wait_beat: got %h/%b want %h/%b",
                             if0.stream_out_TDATA, if0.stream_out_TLAST, e.data, e.last);
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL wait_count: got %0d beats missing want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // T4: no header, no padding -> six beats, header_rdy never raised.
    task automatic test_no_hdr_pad();
        beat_t e;
        int    cyc;
        @(posedge clk); #1;
        if1.header_in = 32'hDEADBEEF; if1.header_vld = 1'b0;
        if1.resp_fields = {64'h9999AAAA_BBBBCCCC, 64'h55556666_77778888, 64'h11112222_33334444};
        if1.resp_val = 1'b1; if1.stream_out_TREADY = 1'b1;
        push3(32'h0, 64'h11112222_33334444, 64'h55556666_77778888, 64'h9999AAAA_BBBBCCCC, 1'b0, 0);
        @(posedge clk); #1;
        if1.resp_val = 1'b0; if1.resp_fields = '0;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 40) begin
            @(negedge clk);
            vectors++;
            if (if1.header_rdy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL nohdr_hrdy: got %b want 0", if1.header_rdy);
            end
            if (if1.stream_out_TVALID === 1'b1) begin
                e = exp_q.pop_front();
                vectors++;
                if ({if1.stream_out_TDATA, if1.stream_out_TLAST, if1.stream_out_TKEEP} !== {e.data, e.last, 4'hF}) begin
                    miscompares++;
                    $display("[TB] FAIL nohdr_beat: got %h/%b/%h want %h/%b/f",
                             if1.stream_out_TDATA, if1.stream_out_TLAST, if1.stream_out_TKEEP, e.data, e.last);
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL nohdr_count: got %0d beats missing want 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        vectors++;
        if ({if1.stream_out_TVALID, if1.resp_rdy, if1.header_rdy} !== 3'b010) begin
            miscompares++;
            $display("[TB] FAIL nohdr_end: got %b want 010",
                     {if1.stream_out_TVALID, if1.resp_rdy, if1.header_rdy});
        end
    endtask

    // T5: five 32-bit fields -> header, 5 words, 3 zero pads.
    task automatic test_five_fields();
        beat_t       e;
        int          cyc;
        logic [31:0] f [5];
        for (int i = 0; i < 5; i++) f[i] = 32'hC0DE0000 + 32'(i * 17 + 3);
        @(posedge clk); #1;
        if2.header_in = 32'h5A5A0005; if2.header_vld = 1'b1;
        if2.resp_fields = {f[4], f[3], f[2], f[1], f[0]};
        if2.resp_val = 1'b1; if2.stream_out_TREADY = 1'b1;
        exp_q.push_back('{data: 32'h5A5A0005, last: 1'b0});
        for (int i = 0; i < 5; i++) exp_q.push_back('{data: f[i], last: 1'b0});
        for (int p = 0; p < 3; p++) exp_q.push_back('{data: 32'h0, last: (p == 2)});
        @(posedge clk); #1;
        if2.resp_val = 1'b0; if2.header_vld = 1'b0; if2.resp_fields = '0;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 40) begin
            @(negedge clk);
            vectors++;
            if ({if2.resp_rdy, if2.header_rdy} !== 2'b00) begin
                miscompares++;
                $display("[TB] FAIL five_busy_rdy: got %b want 00", {if2.resp_rdy, if2.header_rdy});
            end
            if (if2.stream_out_TVALID === 1'b1) begin
                e = exp_q.pop_front();
                vectors++;
                if ({if2.stream_out_TDATA, if2.stream_out_TLAST} !== {e.data, e.last}) begin
                    miscompares++;
                    $display("[TB] FAIL five_beat: got %h/%b want %h/%b",
                             if2.stream_out_TDATA, if2.stream_out_TLAST, e.data, e.last);
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL five_count: got %0d beats missing want 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        vectors++;
        if ({if2.stream_out_TVALID, if2.resp_rdy} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL five_end: got %b want 01", {if2.stream_out_TVALID, if2.resp_rdy});
        end
    endtask

    // T6: reset while beat 4 is stalled, then a fresh packet from its header.
    task automatic test_reset_mid();
        beat_t e;
        int    cyc;
        @(posedge clk); #1;
        if0.header_in = 32'hA5A50001; if0.header_vld = 1'b1; if0.resp_val = 1'b1;
        if0.resp_fields = {64'h9999AAAA_BBBBCCCC, 64'h55556666_77778888, 64'h11112222_33334444};
        if0.stream_out_TREADY = 1'b1;
        @(posedge clk); #1;
        if0.header_vld = 1'b0; if0.resp_val = 1'b0;
        repeat (3) @(posedge clk);
        #1 if0.stream_out_TREADY = 1'b0;
        @(negedge clk);
        vectors++;
        if ({if0.stream_out_TVALID, if0.stream_out_TDATA} !== {1'b1, 32'h55556666}) begin
            miscompares++;
            $display("[TB] FAIL mid_beat4: got %b/%h want 1/55556666",
                     if0.stream_out_TVALID, if0.stream_out_TDATA);
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({if0.stream_out_TVALID, if0.stream_out_TLAST, if0.resp_rdy} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL mid_rst_drop: got %b want 000",
                     {if0.stream_out_TVALID, if0.stream_out_TLAST, if0.resp_rdy});
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if0.header_in = 32'h0BADF00D; if0.header_vld = 1'b1; if0.resp_val = 1'b1;
        if0.resp_fields = {64'hF0F0F0F0_E1E1E1E1, 64'hD2D2D2D2_C3C3C3C3, 64'hB4B4B4B4_A5A5A5A5};
        if0.stream_out_TREADY = 1'b1;
        push3(32'h0BADF00D, 64'hB4B4B4B4_A5A5A5A5, 64'hD2D2D2D2_C3C3C3C3, 64'hF0F0F0F0_E1E1E1E1, 1'b1, 2);
        @(posedge clk); #1;
        if0.header_vld = 1'b0; if0.resp_val = 1'b0;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 40) begin
            @(negedge clk);
            if (if0.stream_out_TVALID === 1'b1) begin
                e = exp_q.pop_front();
                vectors++;
                if ({if0.stream_out_TDATA, if0.stream_out_TLAST} !== {e.data, e.last}) begin
                    miscompares++;
                    $display("[TB] FAIL mid_new_beat: got %h/%b want %h/%b",
                             if0.stream_out_TDATA, if0.stream_out_TLAST, e.data, e.last);
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL mid_new_count: got %0d beats missing want 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        vectors++;
        if (if0.stream_out_TVALID !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mid_no_stale: got %b want 0", if0.stream_out_TVALID);
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_hdr_wait();
        test_no_hdr_pad();
        test_five_fields();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
